des_mode_ctrl: RTL and testbench

- Block-mode controller directly upstream of the iterative encryption core `encrypt_iter`; it feeds that core's k/m/req inputs and consumes its c/ack outputs.
- Accepts a stream of plaintext blocks over a valid/ready interface and applies ECB or CBC chaining (m = p XOR chain in CBC).
- Drives the core through a 4-phase req/ack handshake and returns ciphertext over a valid/ready interface.
- Keeps a 16-bit count of processed blocks.

---
 rtl/des_mode_ctrl.sv | 122 ++++++++++++
 tb/tb_des_mode_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/des_mode_ctrl.sv
// Block-mode controller for the iterative encryption core: applies ECB/CBC
// chaining to plaintext blocks and sequences the core's 4-phase req/ack handshake.
module des_mode_ctrl #(
    parameter int N_B   = 64,
    parameter int N_K   = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_K-1:0]   key,
    input  logic [N_B-1:0]   iv,
    input  logic             init,
    input  logic             cbc_en,
    input  logic [N_B-1:0]   p_data,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [N_B-1:0]   c_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [N_K-1:0]   core_k,
    output logic [N_B-1:0]   core_m,
    output logic             core_req,
    input  logic [N_B-1:0]   core_c,
    input  logic             core_ack,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [1:0]       state_dbg
);

    // Handshakes: a plaintext block transfers on a cycle with p_valid && p_ready,
    // a ciphertext block on c_valid && c_ready; valid holds its data until taken.
    typedef enum logic [1:0] {IDLE, REQ, REL, OUT} state_t;

    state_t             state_q, state_d;
    logic [N_B-1:0]     c_data_q, c_data_d;
    logic [N_K-1:0]     core_k_q, core_k_d;
    logic [N_B-1:0]     core_m_q, core_m_d;
    logic [N_B-1:0]     chain_q, chain_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               core_req_q, core_req_d;
    logic               c_valid_q, c_valid_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        c_data_d  = c_data_q;
        core_k_d  = core_k_q;
        core_m_d  = core_m_q;
        chain_d   = chain_q;
        blk_cnt_d = blk_cnt_q;
        case (state_q)
            IDLE: begin
                // init wins over a waiting block; nothing is accepted that cycle
                if (init) begin
                    chain_d = iv;
                end else if (p_valid) begin
                    core_k_d = key;
                    core_m_d = cbc_en ? (p_data ^ chain_q) : p_data;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (core_ack) begin
                    c_data_d = core_c;
                    chain_d  = core_c;
                    state_d  = REL;
                end
            end
            REL: begin
                if (!core_ack) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (c_ready) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        core_req_d = (state_d == REQ);
        c_valid_d  = (state_d == OUT);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            c_data_q   <= '0;
            core_k_q   <= '0;
            core_m_q   <= '0;
            chain_q    <= '0;
            blk_cnt_q  <= '0;
            core_req_q <= 1'b0;
            c_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_data_q   <= c_data_d;
            core_k_q   <= core_k_d;
            core_m_q   <= core_m_d;
            chain_q    <= chain_d;
            blk_cnt_q  <= blk_cnt_d;
            core_req_q <= core_req_d;
            c_valid_q  <= c_valid_d;
            busy_q     <= busy_d;
        end
    end

    // p_ready is the only combinational output: it must drop in the init cycle
    assign p_ready   = (state_q == IDLE) && !init && !rst;
    assign c_data    = c_data_q;
    assign c_valid   = c_valid_q;
    assign core_k    = core_k_q;
    assign core_m    = core_m_q;
    assign core_req  = core_req_q;
    assign busy      = busy_q;
    assign blk_cnt   = blk_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_des_mode_ctrl.sv
// Bench for des_mode_ctrl: a scripted core model plus a block-level reference
// model (chain value, delivered count, expected ciphertext queue).
module tb_des_mode_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;
  localparam logic [63:0] KAT_K = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_P = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_C = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst, init, cbc_en, p_valid, c_ready, core_ack;
  logic [63:0] key, iv, p_data, core_c;
  logic        p_ready, c_valid, core_req, busy;
  logic [63:0] c_data, core_k, core_m;
  logic [15:0] blk_cnt;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [63:0] m_chain;
  logic [15:0] m_cnt;
  logic [63:0] exp_q[$];
  logic [63:0] last_core_m;

  des_mode_ctrl #(.N_B(64), .N_K(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .key(key), .iv(iv), .init(init), .cbc_en(cbc_en),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .core_k(core_k), .core_m(core_m), .core_req(core_req),
    .core_c(core_c), .core_ack(core_ack), .busy(busy),
    .blk_cnt(blk_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // stand-in cipher: known answer for the reference vector, a fixed mix otherwise
  function automatic logic [63:0] core_fn(input logic [63:0] k, input logic [63:0] m);
    if (k == KAT_K && m == KAT_P) return KAT_C;
    return {m[40:0], m[63:41]} ^ k ^ 64'hA5A50F0F3C3C9696;
  endfunction

  // one block from accept to delivery, checking every phase on the way
  task automatic run_block(input logic [63:0] p, input logic [63:0] k, input logic cbc,
                           input int ack_dly, input int ack_hold, input int out_wait,
                           input logic init_in_req);
    logic [63:0] em, ec, want;
    em = cbc ? (p ^ m_chain) : p;
    ec = core_fn(k, em);
    @(negedge clk);
    checks++; if (p_ready !== 1'b1 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL idle_ready p_ready=%0b state=%0d exp 1/%0d", p_ready, state_dbg, ST_IDLE); end
    p_data = p; key = k; cbc_en = cbc; p_valid = 1'b1;
    @(negedge clk);
    p_valid = 1'b0; p_data = rand64(); key = rand64(); cbc_en = $urandom_range(0, 1);
    last_core_m = core_m;
    checks++; if ({core_req, busy, p_ready} !== 3'b110) begin errors++; $display("FAIL req_rise req/busy/rdy=%b exp 110", {core_req, busy, p_ready}); end
    checks++; if (core_m !== em) begin errors++; $display("FAIL core_m got=%h exp=%h", core_m, em); end
    checks++; if (core_k !== k) begin errors++; $display("FAIL core_k got=%h exp=%h", core_k, k); end
    if (init_in_req) begin
      init = 1'b1; iv = rand64();
      @(negedge clk);
      init = 1'b0;
      checks++; if (state_dbg !== ST_REQ || core_req !== 1'b1) begin errors++; $display("FAIL init_in_req state=%0d req=%0b exp %0d/1", state_dbg, core_req, ST_REQ); end
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      checks++; if (core_req !== 1'b1 || core_m !== em || core_k !== k) begin errors++; $display("FAIL req_hold req=%0b m=%h k=%h exp 1/%h/%h", core_req, core_m, core_k, em, k); end
    end
    core_ack = 1'b1; core_c = ec; exp_q.push_back(ec);
    @(negedge clk);
    core_c = rand64();
    checks++; if (state_dbg !== ST_REL || core_req !== 1'b0 || c_valid !== 1'b0) begin errors++; $display("FAIL rel_enter state=%0d req=%0b cv=%0b exp %0d/0/0", state_dbg, core_req, c_valid, ST_REL); end
    for (int i = 1; i < ack_hold; i++) begin
      @(negedge clk);
      checks++; if (state_dbg !== ST_REL || core_req !== 1'b0 || c_valid !== 1'b0) begin errors++; $display("FAIL rel_hold state=%0d req=%0b cv=%0b exp %0d/0/0", state_dbg, core_req, c_valid, ST_REL); end
    end
    core_ack = 1'b0;
    @(negedge clk);
    want = exp_q.pop_front();
    checks++; if (c_valid !== 1'b1 || state_dbg !== ST_OUT) begin errors++; $display("FAIL out_enter cv=%0b state=%0d exp 1/%0d", c_valid, state_dbg, ST_OUT); end
    for (int i = 0; i < out_wait; i++) begin
      core_ack = $urandom_range(0, 1);
      checks++; if (c_valid !== 1'b1 || c_data !== want || p_ready !== 1'b0 || blk_cnt !== m_cnt) begin errors++; $display("FAIL backpressure cv=%0b c=%h rdy=%0b cnt=%h exp 1/%h/0/%h", c_valid, c_data, p_ready, blk_cnt, want, m_cnt); end
      @(negedge clk);
    end
    core_ack = 1'b0;
    checks++; if (c_valid !== 1'b1 || c_data !== want) begin errors++; $display("FAIL c_data got=%h exp=%h cv=%0b", c_data, want, c_valid); end
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    m_cnt = m_cnt + 16'd1;
    m_chain = want;
    checks++; if (c_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE || blk_cnt !== m_cnt) begin errors++; $display("FAIL deliver cv=%0b busy=%0b state=%0d cnt=%h exp 0/0/%0d/%h", c_valid, busy, state_dbg, blk_cnt, ST_IDLE, m_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if ({p_ready, c_valid, core_req, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp 0000", {p_ready, c_valid, core_req, busy}); end
    checks++; if (c_data !== 64'd0 || core_k !== 64'd0 || core_m !== 64'd0 || blk_cnt !== 16'd0) begin errors++; $display("FAIL reset_data c=%h k=%h m=%h cnt=%h exp all 0", c_data, core_k, core_m, blk_cnt); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_chain = '0; m_cnt = '0; exp_q.delete();
  endtask

  task automatic test_ecb_kat();
    run_block(KAT_P, KAT_K, 1'b0, 2, 1, 0, 1'b0);
    checks++; if (last_core_m !== KAT_P) begin errors++; $display("FAIL kat_core_m got=%h exp=%h", last_core_m, KAT_P); end
    checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL kat_cnt got=%h exp=0001", blk_cnt); end
  endtask

  task automatic do_init(input logic [63:0] v, input logic with_valid);
    @(negedge clk);
    init = 1'b1; iv = v; p_valid = with_valid; p_data = rand64();
    #1;
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL init_p_ready got=%0b exp=0", p_ready); end
    @(negedge clk);
    init = 1'b0; p_valid = 1'b0;
    m_chain = v;
    checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0 || core_req !== 1'b0) begin errors++; $display("FAIL init_no_accept state=%0d busy=%0b req=%0b exp %0d/0/0", state_dbg, busy, core_req, ST_IDLE); end
  endtask

  task automatic test_cbc_chain();
    do_init(64'd0, 1'b0);
    run_block(KAT_P, KAT_K, 1'b1, 1, 1, 0, 1'b0);
    checks++; if (last_core_m !== KAT_P) begin errors++; $display("FAIL cbc_blk1_m got=%h exp=%h", last_core_m, KAT_P); end
    run_block(KAT_P, KAT_K, 1'b1, 1, 1, 0, 1'b0);
    checks++; if (last_core_m !== 64'h84CB563386A179EA) begin errors++; $display("FAIL cbc_blk2_m got=%h exp=84cb563386a179ea", last_core_m); end
  endtask

  task automatic test_handshake();
    run_block(rand64(), rand64(), 1'b1, 3, 6, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_block(rand64(), rand64(), 1'b0, 0, 1, 10, 1'b0);
  endtask

  task automatic test_priority();
    do_init(rand64(), 1'b1);
    run_block(rand64(), rand64(), 1'b1, 1, 2, 1, 1'b1);
    run_block(rand64(), rand64(), 1'b1, 0, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 4) == 0) do_init(rand64(), 1'b1);
      run_block(rand64(), rand64(), 1'(($urandom_range(0, 2)) != 0),
                $urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(0, 3),
                1'($urandom_range(0, 5) == 0));
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.blk_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    m_cnt = 16'hFFFF;
    run_block(rand64(), rand64(), 1'b0, 1, 1, 2, 1'b0);
    checks++; if (blk_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got=%h exp=0000", blk_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    p_data = rand64(); key = rand64(); cbc_en = 1'b1; p_valid = 1'b1;
    @(negedge clk);
    p_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({core_req, busy, c_valid, p_ready} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got=%b exp 0000", {core_req, busy, c_valid, p_ready}); end
    checks++; if (c_data !== 64'd0 || core_k !== 64'd0 || core_m !== 64'd0 || blk_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_data c=%h k=%h m=%h cnt=%h exp all 0", c_data, core_k, core_m, blk_cnt); end
    @(negedge clk);
    rst = 1'b0;
    m_chain = '0; m_cnt = '0; exp_q.delete();
    run_block(rand64(), rand64(), 1'b1, 1, 1, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; init = 1'b0; cbc_en = 1'b0; p_valid = 1'b0; c_ready = 1'b0;
    core_ack = 1'b0; key = '0; iv = '0; p_data = '0; core_c = '0;
    m_chain = '0; m_cnt = '0; last_core_m = '0;
    #1;
    test_reset();
    test_ecb_kat();
    test_cbc_chain();
    test_handshake();
    test_backpressure();
    test_priority();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
